mem_map_dma: RTL and testbench

MEM_MAP_DMA -- requirements
Module: mem_map_dma

---
 rtl/mem_map_dma.sv | 128 ++++++++++++
 tb/tb_mem_map_dma.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_map_dma.sv
// mem_map_dma: CPU memory map (RAM/IO/joypads/SRAM/ROM) with a 256-byte sprite DMA engine
module mem_map_dma #(
  parameter int          RAM_AW   = 11,
  parameter int          SRAM_AW  = 13,
  parameter int          ROM_AW   = 15,
  parameter int          IOREG_AW = 3,
  parameter int          VEC_OVR  = 1,
  parameter logic [15:0] VEC_ADDR = 16'h8000
) (
  input  logic              clk,
  input  logic              b_rst,
  input  logic [15:0]       cpu_addr_out,
  input  logic [7:0]        cpu_data_out,
  input  logic              ren,
  input  logic              wen,
  output logic [7:0]        cpu_data_in,
  output logic              rdy,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic [7:0]        joy1_btn,
  input  logic [7:0]        joy2_btn,
  output logic              oam_wen,
  output logic [7:0]        oam_addr,
  output logic [7:0]        oam_data
);
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, RD, WR} st_t;
  st_t st_q, st_d;
  logic [7:0] idx_q, idx_d, page_q, page_d, byte_q, byte_d;
  logic [7:0] sh1_q, sh1_d, sh2_q, sh2_d;
  logic strobe_q, strobe_d, cyc_par_q, cyc_par_d;
  logic [7:0] ram_q [2**RAM_AW];
  logic [7:0] sram_q [2**SRAM_AW];
  logic [7:0] io_q [2**IOREG_AW];
  logic [15:0] a;
  logic [7:0] mem_rd, other_rd;
  logic cpu_rd, cpu_wr, is_vec, ram_we, sram_we, io_we;
  // Address source (DMA fetch or CPU), region decode and combinational read data
  always_comb begin
    rdy = st_q == IDLE;
    cpu_rd = ren && !wen && rdy;
    cpu_wr = wen && rdy;
    a = st_q == RD ? {page_q, idx_q} : cpu_addr_out;
    rom_addr = a[ROM_AW-1:0];
    is_vec = (VEC_OVR != 0) && a[15:3] == 13'h1FFF && a[2:1] != 2'b00;
    mem_rd = a[15] ? (is_vec ? (a[0] ? VEC_ADDR[15:8] : VEC_ADDR[7:0]) : rom_data)
           : a[14:13] == 2'd0 ? ram_q[a[RAM_AW-1:0]]
           : a[14:13] == 2'd3 ? sram_q[a[SRAM_AW-1:0]]
           : (a[14:13] == 2'd1 && st_q != RD) ? io_q[a[IOREG_AW-1:0]]
           : 8'h00;
    other_rd = cpu_addr_out == 16'h4014 ? page_q
             : cpu_addr_out == 16'h4016 ? {7'b0, strobe_q ? joy1_btn[0] : sh1_q[0]}
             : cpu_addr_out == 16'h4017 ? {7'b0, strobe_q ? joy2_btn[0] : sh2_q[0]}
             : 8'h00;
    cpu_data_in = cpu_rd ? (cpu_addr_out[15:13] == 3'd2 ? other_rd : mem_rd) : 8'h00;
    ram_we = cpu_wr && cpu_addr_out[15:13] == 3'd0;
    io_we = cpu_wr && cpu_addr_out[15:13] == 3'd1;
    sram_we = cpu_wr && cpu_addr_out[15:13] == 3'd3;
  end
  // Joypad strobe/shift registers and the free-running cycle parity
  always_comb begin
    cyc_par_d = ~cyc_par_q;
    strobe_d = (cpu_wr && cpu_addr_out == 16'h4016) ? cpu_data_out[0] : strobe_q;
    sh1_d = strobe_q ? joy1_btn : (cpu_rd && cpu_addr_out == 16'h4016) ? {1'b1, sh1_q[7:1]} : sh1_q;
    sh2_d = strobe_q ? joy2_btn : (cpu_rd && cpu_addr_out == 16'h4017) ? {1'b1, sh2_q[7:1]} : sh2_q;
  end
  // DMA next-state: halt, optional alignment cycle, then 256 read/write pairs
  always_comb begin
    st_d = st_q;
    idx_d = idx_q;
    page_d = page_q;
    byte_d = byte_q;
    oam_wen = 1'b0;
    oam_addr = idx_q;
    oam_data = byte_q;
    case (st_q)
      IDLE: if (cpu_wr && cpu_addr_out == 16'h4014) begin
        st_d = HALT;
        page_d = cpu_data_out;
      end
      HALT: st_d = cyc_par_q ? ALIGN : RD;
      ALIGN: st_d = RD;
      RD: begin
        byte_d = mem_rd;
        st_d = WR;
      end
      WR: begin
        oam_wen = 1'b1;
        idx_d = idx_q + 8'd1;
        st_d = idx_q == 8'hFF ? IDLE : RD;
      end
      default: st_d = IDLE;
    endcase
  end
  // Control and DMA state registers
  always_ff @(posedge clk or negedge b_rst) begin
    if (!b_rst) begin
      st_q <= IDLE;
      idx_q <= '0;
      page_q <= '0;
      byte_q <= '0;
      sh1_q <= '0;
      sh2_q <= '0;
      strobe_q <= 1'b0;
      cyc_par_q <= 1'b0;
    end else begin
      st_q <= st_d;
      idx_q <= idx_d;
      page_q <= page_d;
      byte_q <= byte_d;
      sh1_q <= sh1_d;
      sh2_q <= sh2_d;
      strobe_q <= strobe_d;
      cyc_par_q <= cyc_par_d;
    end
  end
  // Internal RAM, SRAM and IO registers: cleared on reset, written by CPU stores only
  always_ff @(posedge clk or negedge b_rst) begin
    if (!b_rst) begin
      for (int i = 0; i < 2**RAM_AW; i++) ram_q[i] <= '0;
      for (int i = 0; i < 2**SRAM_AW; i++) sram_q[i] <= '0;
      for (int i = 0; i < 2**IOREG_AW; i++) io_q[i] <= '0;
    end else begin
      if (ram_we) ram_q[cpu_addr_out[RAM_AW-1:0]] <= cpu_data_out;
      if (sram_we) sram_q[cpu_addr_out[SRAM_AW-1:0]] <= cpu_data_out;
      if (io_we) io_q[cpu_addr_out[IOREG_AW-1:0]] <= cpu_data_out;
    end
  end
endmodule

// File: tb/tb_mem_map_dma.sv
// tb_mem_map_dma: scoreboard bench for the memory map, joypads and sprite DMA
module tb_mem_map_dma;
  logic clk = 1'b0, b_rst = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0] wdat = '0, joy1 = '0, joy2 = '0;
  logic ren = 1'b0, wen = 1'b0;
  logic [7:0] rd, rd8, rom_data, rom_data8, oam_addr, oam_data, oam_addr8, oam_data8;
  logic [14:0] rom_addr, rom_addr8;
  logic rdy, rdy8, oam_wen, oam_wen8, par;
  int checks = 0, fails = 0;
  logic [7:0] rq[$];
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input logic [14:0] x);
    return x[7:0] ^ {1'b0, x[14:8]} ^ 8'h3C;
  endfunction
  assign rom_data = rom_f(rom_addr);
  assign rom_data8 = rom_f(rom_addr8);

  // Expected cycle parity: 0 at reset, flips on every rising edge
  always @(posedge clk or negedge b_rst)
    if (!b_rst) par <= 1'b0;
    else par <= ~par;

  mem_map_dma #(.VEC_ADDR(16'hC123)) dut (
    .clk(clk), .b_rst(b_rst), .cpu_addr_out(addr), .cpu_data_out(wdat), .ren(ren), .wen(wen),
    .cpu_data_in(rd), .rdy(rdy), .rom_addr(rom_addr), .rom_data(rom_data),
    .joy1_btn(joy1), .joy2_btn(joy2), .oam_wen(oam_wen), .oam_addr(oam_addr), .oam_data(oam_data));

  mem_map_dma #(.RAM_AW(8), .VEC_ADDR(16'hC123)) dut8 (
    .clk(clk), .b_rst(b_rst), .cpu_addr_out(addr), .cpu_data_out(wdat), .ren(ren), .wen(wen),
    .cpu_data_in(rd8), .rdy(rdy8), .rom_addr(rom_addr8), .rom_data(rom_data8),
    .joy1_btn(joy1), .joy2_btn(joy2), .oam_wen(oam_wen8), .oam_addr(oam_addr8), .oam_data(oam_data8));

  task automatic cpu_wr(input logic [15:0] ad, input logic [7:0] d);
    @(negedge clk);
    addr = ad; wdat = d; wen = 1'b1; ren = 1'b0;
  endtask

  task automatic cpu_rd(input logic [15:0] ad, output logic [7:0] d, output logic [7:0] d8);
    @(negedge clk);
    addr = ad; ren = 1'b1; wen = 1'b0;
    #1;
    d = rd; d8 = rd8;
  endtask

  task automatic idle();
    @(negedge clk);
    ren = 1'b0; wen = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d, d8, e;
    repeat (2) @(negedge clk);
    addr = 16'h4014; ren = 1'b1;
    #1;
    checks++; if (rdy !== 1'b1) begin fails++; $display("FAIL reset_rdy got=%b exp=1", rdy); end
    checks++; if (oam_wen !== 1'b0) begin fails++; $display("FAIL reset_oam_wen got=%b exp=0", oam_wen); end
    checks++; if ({oam_addr, oam_data} !== 16'h0000) begin fails++; $display("FAIL reset_oam got=%h exp=0000", {oam_addr, oam_data}); end
    ren = 1'b0;
    @(negedge clk);
    b_rst = 1'b1;
    rq.push_back(8'h00); cpu_rd(16'h4014, d, d8); e = rq.pop_front();
    checks++; if (d !== e) begin fails++; $display("FAIL reset_page got=%h exp=%h", d, e); end
    rq.push_back(8'h00); cpu_rd(16'h0005, d, d8); e = rq.pop_front();
    checks++; if (d !== e) begin fails++; $display("FAIL reset_ram got=%h exp=%h", d, e); end
    idle();
  endtask

  task automatic test_mem_mirror();
    logic [15:0] ad [6] = '{16'h0805, 16'h1805, 16'h0005, 16'h7F03, 16'h2009, 16'h3FF9};
    logic [7:0] ex [6] = '{8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h77, 8'h77};
    logic [7:0] d, d8, e;
    cpu_wr(16'h0005, 8'hA5);
    cpu_wr(16'h6003, 8'h3C);
    cpu_wr(16'h2001, 8'h77);
    for (int i = 0; i < 6; i++) begin
      rq.push_back(ex[i]); cpu_rd(ad[i], d, d8); e = rq.pop_front();
      checks++; if (d !== e) begin fails++; $display("FAIL mirror addr=%h got=%h exp=%h", ad[i], d, e); end
    end
    rq.push_back(8'h3C); cpu_rd(16'h6003, d, d8); e = rq.pop_front();
    checks++; if (d !== e) begin fails++; $display("FAIL sram got=%h exp=%h", d, e); end
    rq.push_back(8'hA5); cpu_rd(16'h0105, d, d8); e = rq.pop_front();
    checks++; if (d8 !== e) begin fails++; $display("FAIL ram_aw8_mirror got=%h exp=%h", d8, e); end
    rq.push_back(8'hA5); cpu_rd(16'h1F05, d, d8); e = rq.pop_front();
    checks++; if (d8 !== e) begin fails++; $display("FAIL ram_aw8_top got=%h exp=%h", d8, e); end
    idle();
  endtask

  task automatic test_rom_vec();
    logic [15:0] ad [7] = '{16'hFFFC, 16'hFFFD, 16'hFFFA, 16'hFFFB, 16'hFFFE, 16'hFFFF, 16'hFFF9};
    logic [7:0] ex [7];
    logic [7:0] d, d8, e;
    ex = '{8'h23, 8'hC1, 8'h23, 8'hC1, 8'h23, 8'hC1, rom_f(15'h7FF9)};
    for (int i = 0; i < 7; i++) begin
      rq.push_back(ex[i]); cpu_rd(ad[i], d, d8); e = rq.pop_front();
      checks++; if (d !== e) begin fails++; $display("FAIL vec addr=%h got=%h exp=%h", ad[i], d, e); end
    end
    cpu_wr(16'h9000, 8'hFF);
    rq.push_back(rom_f(15'h1000)); cpu_rd(16'h9000, d, d8); e = rq.pop_front();
    checks++; if (d !== e) begin fails++; $display("FAIL rom_write got=%h exp=%h", d, e); end
    idle();
  endtask

  task automatic test_joypad();
    logic [7:0] d, d8, e;
    logic [9:0] j1 = 10'b11_0000_0101;
    logic [8:0] j2 = 9'b1_1100_0000;
    joy1 = 8'b0000_0101; joy2 = 8'hC0;
    cpu_wr(16'h4016, 8'h01);
    cpu_wr(16'h4016, 8'h00);
    for (int i = 0; i < 10; i++) rq.push_back({7'b0, j1[i]});
    for (int i = 0; i < 10; i++) begin
      cpu_rd(16'h4016, d, d8); e = rq.pop_front();
      checks++; if (d !== e) begin fails++; $display("FAIL joy1 read=%0d got=%h exp=%h", i, d, e); end
    end
    for (int i = 0; i < 9; i++) rq.push_back({7'b0, j2[i]});
    for (int i = 0; i < 9; i++) begin
      cpu_rd(16'h4017, d, d8); e = rq.pop_front();
      checks++; if (d !== e) begin fails++; $display("FAIL joy2 read=%0d got=%h exp=%h", i, d, e); end
    end
    cpu_wr(16'h4016, 8'h01);
    joy1 = 8'h04;
    rq.push_back(8'h00); cpu_rd(16'h4016, d, d8); e = rq.pop_front();
    checks++; if (d !== e) begin fails++; $display("FAIL joy_live0 got=%h exp=%h", d, e); end
    joy1 = 8'h05;
    for (int i = 0; i < 2; i++) begin
      rq.push_back(8'h01); cpu_rd(16'h4016, d, d8); e = rq.pop_front();
      checks++; if (d !== e) begin fails++; $display("FAIL joy_live1 read=%0d got=%h exp=%h", i, d, e); end
    end
    cpu_wr(16'h4016, 8'h00);
    idle();
  endtask

  task automatic test_ren_wen();
    logic [7:0] d, d8, e;
    @(negedge clk);
    addr = 16'h0010; wdat = 8'h33; ren = 1'b1; wen = 1'b1;
    rq.push_back(8'h00);
    #1; e = rq.pop_front();
    checks++; if (rd !== e) begin fails++; $display("FAIL ren_wen_same got=%h exp=%h", rd, e); end
    rq.push_back(8'h33); cpu_rd(16'h0010, d, d8); e = rq.pop_front();
    checks++; if (d !== e) begin fails++; $display("FAIL ren_wen_after got=%h exp=%h", d, e); end
    @(negedge clk);
    addr = 16'h0005; ren = 1'b0; wen = 1'b0;
    rq.push_back(8'h00);
    #1; e = rq.pop_front();
    checks++; if (rd !== e) begin fails++; $display("FAIL ren_low got=%h exp=%h", rd, e); end
  endtask

  task automatic fill_page();
    for (int i = 0; i < 256; i++) cpu_wr(16'h0200 + 16'(i), 8'(i) ^ 8'h5A);
    idle();
  endtask

  task automatic test_dma(input logic want_odd, input logic zero);
    int low = 0, pulses = 0, cyc = 0;
    logic [15:0] e, g;
    for (int i = 0; i < 256; i++) sb.push_back({8'(i), zero ? 8'h00 : (8'(i) ^ 8'h5A)});
    @(negedge clk);
    ren = 1'b0; wen = 1'b0;
    if (par == want_odd) @(negedge clk);
    addr = 16'h4014; wdat = 8'h02; wen = 1'b1;
    while (cyc < 700) begin
      @(negedge clk);
      wen = 1'b0;
      ren = cyc == 50;
      addr = cyc == 50 ? 16'h0205 : 16'h0000;
      cyc++;
      #1;
      if (cyc == 51) begin
        checks++; if (rd !== 8'h00) begin fails++; $display("FAIL dma_cpu_read got=%h exp=00", rd); end
      end
      if (!rdy) low++;
      if (oam_wen) begin
        pulses++;
        g = {oam_addr, oam_data};
        checks++;
        if (sb.size() == 0) begin fails++; $display("FAIL dma_extra got=%h exp=none", g); end
        else begin
          e = sb.pop_front();
          if (g !== e) begin fails++; $display("FAIL dma_oam addr_data got=%h exp=%h", g, e); end
        end
      end
      if (rdy && low > 0) break;
    end
    ren = 1'b0;
    checks++; if (low !== 513 + int'(want_odd)) begin fails++; $display("FAIL dma_rdy_low got=%0d exp=%0d", low, 513 + int'(want_odd)); end
    checks++; if (pulses !== 256) begin fails++; $display("FAIL dma_pulses got=%0d exp=256", pulses); end
    sb.delete();
  endtask

  task automatic test_reset_mid_dma();
    logic seen = 1'b0;
    logic [7:0] d, d8, e;
    @(negedge clk);
    addr = 16'h4014; wdat = 8'h02; wen = 1'b1;
    repeat (100) begin @(negedge clk); wen = 1'b0; addr = '0; end
    #1;
    checks++; if (rdy !== 1'b0) begin fails++; $display("FAIL mid_dma_busy got=%b exp=0", rdy); end
    #1 b_rst = 1'b0;
    #1;
    checks++; if (rdy !== 1'b1) begin fails++; $display("FAIL abort_rdy got=%b exp=1", rdy); end
    checks++; if ({oam_wen, oam_addr} !== 9'h000) begin fails++; $display("FAIL abort_oam got=%h exp=000", {oam_wen, oam_addr}); end
    repeat (3) begin @(negedge clk); #1 seen = seen | oam_wen; end
    checks++; if (seen !== 1'b0) begin fails++; $display("FAIL abort_no_pulse got=%b exp=0", seen); end
    b_rst = 1'b1;
    rq.push_back(8'h00); cpu_rd(16'h0200, d, d8); e = rq.pop_front();
    checks++; if (d !== e) begin fails++; $display("FAIL abort_ram_cleared got=%h exp=%h", d, e); end
    idle();
    test_dma(1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_mem_mirror();
    test_rom_vec();
    test_joypad();
    test_ren_wen();
    fill_page();
    test_dma(1'b0, 1'b0);
    test_dma(1'b1, 1'b0);
    test_reset_mid_dma();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
